// File: rtl/simmem_pkg.sv
// Shared capacities for the simulated memory controller banks.
package simmem_pkg;

  localparam int unsigned WriteRespBankCapacity = 8;
  localparam int unsigned ReadDataBankCapacity  = 8;

endpackage

// File: rtl/simmem_rr_picker.sv
// Wrap-around find-first: returns the first set bit of vec at or above ptr,
// searching upward and wrapping from NumSlots-1 back to 0.
module simmem_rr_picker #(
  parameter  int unsigned NumSlots = 8,
  localparam int unsigned IdxWidth = $clog2(NumSlots)
) (
  input  logic [NumSlots-1:0] vec,
  input  logic [IdxWidth-1:0] ptr,
  output logic                found,
  output logic [IdxWidth-1:0] index
);

  // Scan positions ptr, ptr+1, ... modulo NumSlots; the first hit wins.
  always_comb begin : pick_search
    int unsigned pos;
    found = 1'b0;
    index = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= NumSlots) pos = pos - NumSlots;
      if (!found && vec[IdxWidth'(pos)]) begin
        found = 1'b1;
        index = IdxWidth'(pos);
      end
    end
  end

endmodule

// File: rtl/simmem_release_arbiter.sv
// Release arbiter: picks one enabled bank slot per grant, hands it to the
// message bank with a valid/ready handshake, and confirms each release back to
// the delay calculator with a one-cycle one-hot pulse. A slot is granted at
// most once per enable assertion.
// Build option: SIMMEM_RELEASE_ARB_FIXED_PRIO_EN selects lowest-index-first
// priority with the pointer pinned to 0; otherwise arbitration is round-robin.
module simmem_release_arbiter
  import simmem_pkg::*;
#(
  parameter  int unsigned NumSlots     = WriteRespBankCapacity,
  localparam int unsigned SlotIdxWidth = $clog2(NumSlots)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumSlots-1:0]     release_en_onehot_i,
  output logic                    grant_valid_o,
  input  logic                    grant_ready_i,
  output logic [SlotIdxWidth-1:0] grant_addr_o,
  output logic [NumSlots-1:0]     released_addr_onehot_o
);

  typedef enum logic {
    Idle  = 1'b0,
    Grant = 1'b1
  } state_e;

  state_e                  state_q;
  logic [NumSlots-1:0]     inflight_q;
  logic [SlotIdxWidth-1:0] ptr_q;

  logic [NumSlots-1:0]     eligible_c;
  logic [NumSlots-1:0]     grant_mask_c;
  logic [NumSlots-1:0]     pick_vec_c;
  logic [SlotIdxWidth-1:0] next_ptr_c;
  logic [SlotIdxWidth-1:0] pick_ptr_c;
  logic [SlotIdxWidth-1:0] pick_idx_c;
  logic                    pick_found_c;
  logic                    handshake_c;

  // Eligibility, handshake detection and the picker's search window. On a
  // handshake the search starts just past the slot being released and skips it.
  always_comb begin
    eligible_c   = release_en_onehot_i & ~inflight_q;
    grant_mask_c = NumSlots'(1) << grant_addr_o;
    handshake_c  = (state_q == Grant) && grant_ready_i;
`ifdef SIMMEM_RELEASE_ARB_FIXED_PRIO_EN
    next_ptr_c   = '0;
`else
    next_ptr_c   = (grant_addr_o == SlotIdxWidth'(NumSlots - 1)) ?
                   '0 : grant_addr_o + SlotIdxWidth'(1);
`endif
    pick_vec_c   = handshake_c ? (eligible_c & ~grant_mask_c) : eligible_c;
    pick_ptr_c   = handshake_c ? next_ptr_c : ptr_q;
  end

  simmem_rr_picker #(
    .NumSlots (NumSlots)
  ) u_picker (
    .vec   (pick_vec_c),
    .ptr   (pick_ptr_c),
    .found (pick_found_c),
    .index (pick_idx_c)
  );

  // Grant FSM with registered outputs, in-flight tracking and release pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q                <= Idle;
      grant_valid_o          <= 1'b0;
      grant_addr_o           <= '0;
      released_addr_onehot_o <= '0;
      inflight_q             <= '0;
      ptr_q                  <= '0;
    end else begin
      // A slot stays in flight only while its enable remains asserted.
      inflight_q             <= (inflight_q | (handshake_c ? grant_mask_c : '0)) &
                                release_en_onehot_i;
      released_addr_onehot_o <= handshake_c ? grant_mask_c : '0;
      case (state_q)
        Idle: begin
          if (pick_found_c) begin
            state_q       <= Grant;
            grant_valid_o <= 1'b1;
            grant_addr_o  <= pick_idx_c;
          end
        end
        Grant: begin
          if (grant_ready_i) begin
            ptr_q <= next_ptr_c;
            if (pick_found_c) begin
              grant_addr_o <= pick_idx_c;
            end else begin
              state_q       <= Idle;
              grant_valid_o <= 1'b0;
            end
          end
        end
        default: begin
          state_q       <= Idle;
          grant_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
